gcd_fold_engine: RTL and testbench
==================================

GCD_FOLD_ENGINE -- requirements
Module: gcd_fold_engine

Interface
REQ-001 Parameter W, default 8, operand and result width in bits (2..16).
REQ-002 Parameter N_OPS, default 3, number of operands folded into one GCD (2..8).
REQ-003 Reset rst, synchronous, active-high; clock clk.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 num_okey  input  1  operand-entry strobe; level held by the user.
REQ-007 number  input  W  operand value, sampled while num_okey is high.
REQ-008 result  output  W  final GCD; valid while done=1.
REQ-009 done  output  1  result valid; held until rst or a new entry starts.
REQ-010 busy  output  1  high during the COMPUTE state.
REQ-011 zero_err  output  1  high with done when all operands were zero.
REQ-012 ssd  output  7  seven-segment status/result pattern.

Function
REQ-013 FSM states: IDLE, HOLD, NEXT, COMPUTE, DONE.
REQ-014 IDLE: ssd=1000000; num_okey=1 -> HOLD, operand index k=0.
REQ-015 HOLD: capture number into op[k] every cycle; ssd=1011100; num_okey=0 -> k incremented; if the new k equals N_OPS -> COMPUTE, else -> NEXT.
REQ-016 NEXT: ssd=1010100; num_okey=1 -> HOLD; the last value captured in HOLD is final.
REQ-017 On COMPUTE entry: a=op[0], b=op[1], fold index j=2.
REQ-018 One COMPUTE step per cycle: if a==b or b==0, pair result = a; else if a==0, pair result = b; else if a>b, a<=a-b; else b<=b-a.
REQ-019 On a pair result: if j<N_OPS, a<=result, b<=op[j], j++; else latch result and go to DONE.
REQ-020 gcd(x,0)=x and gcd(0,0)=0; a zero operand costs exactly one cycle.
REQ-021 All arithmetic is unsigned W-bit; no subtraction underflows because the larger operand is always the minuend.
REQ-022 COMPUTE: busy=1, ssd=0111111; worst-case latency is at most N_OPS*2^W cycles.
REQ-023 DONE: done=1; zero_err=1 iff result==0; ssd = hex glyph of result[3:0], or 1111001 when zero_err=1.
REQ-024 DONE with num_okey=1 -> HOLD with k=0; done and zero_err clear on that same edge (new entry).
REQ-025 num_okey changes during COMPUTE are ignored; the FSM does not sample num_okey while busy.
REQ-026 Undefined state encodings return to IDLE on the next clock.

Reset
REQ-027 rst wins over every other event, including mid-entry and mid-COMPUTE; next state is IDLE.
REQ-028 After rst: result=0, done=0, busy=0, zero_err=0, ssd=1000000, k=j=0, all op[] cleared to 0.

Structure
REQ-029 Shared package gcd_pkg holds the state enumeration and the glyph constants (IDLE, HOLD, NEXT, BUSY, ERR).
REQ-030 The 4-bit hex-to-seven-segment table sits in one combinational sub-module ssd_hex; everything else is in gcd_fold_engine.
REQ-031 Operand storage is a register array of N_OPS x W; no memory macro.

Verification
REQ-032 W=8, N_OPS=3: enter 12, 18, 30 -> done=1, result=6, ssd=hex 6, zero_err=0.
REQ-033 Enter 0, 0, 0 -> result=0, zero_err=1, ssd=1111001; COMPUTE lasts exactly 2 cycles.
REQ-034 Enter 255, 1, 7 -> result=1; busy drops on the same edge that done rises.
REQ-035 Assert rst during COMPUTE of 200, 150, 100 -> next cycle is IDLE, all outputs at reset values; re-entering 200, 150, 100 gives result=50.
REQ-036 Toggle num_okey during COMPUTE -> no change to result; in DONE, raise num_okey -> done=0 and op[0] is recaptured.
REQ-037 W=4, N_OPS=2: enter 15, 10 -> result=5; measured latency matches the per-cycle step rule of REQ-018.

Source files
------------

// File: rtl/gcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gcd_pkg : FSM state encoding and seven-segment status glyphs        |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package gcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_NEXT    = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [6:0] C_GLYPH_IDLE = 7'b1000000;
  localparam logic [6:0] C_GLYPH_HOLD = 7'b1011100;
  localparam logic [6:0] C_GLYPH_NEXT = 7'b1010100;
  localparam logic [6:0] C_GLYPH_BUSY = 7'b0111111;
  localparam logic [6:0] C_GLYPH_ERR  = 7'b1111001;

endpackage
`default_nettype wire

// File: rtl/ssd_hex.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ssd_hex : 4-bit hex digit to active-low gfedcba segment pattern     |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module ssd_hex (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/gcd_fold_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gcd_fold_engine : captures N_OPS operands, folds them through a     |
// | subtractive GCD one step per cycle. rev 1.0                         |
// +--------------------------------------------------------------------+
module gcd_fold_engine
  import gcd_pkg::*;
#(
  parameter int W     = 8,
  parameter int N_OPS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         num_okey,
  input  logic [W-1:0] number,
  output logic [W-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         zero_err,
  output logic [6:0]   ssd
);

  localparam int KW = $clog2(N_OPS + 1);

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [KW-1:0]  j_q, j_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   op_q [N_OPS];
  logic [W-1:0]   op_d [N_OPS];

  logic [KW-1:0]  k_inc;
  logic [W-1:0]   op_at_j;
  logic           pair_hit;
  logic [W-1:0]   pair_val;
  logic [3:0]     nibble;
  logic [6:0]     hex_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      j_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      j_q      <= j_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      op_q     <= op_d;
    end
  end

  // A zero on either side, or equal operands, settles the pair in one cycle.
  always_comb begin
    k_inc    = k_q + KW'(1);
    pair_hit = (a_q == b_q) || (b_q == '0) || (a_q == '0);
    pair_val = ((a_q == '0) && (b_q != '0)) ? b_q : a_q;
    op_at_j  = '0;
    for (int i = 0; i < N_OPS; i++) begin
      if (j_q == KW'(i)) op_at_j = op_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    j_d      = j_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    op_d     = op_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (num_okey) begin
          state_d = ST_HOLD;
          k_d     = '0;
        end
      end
      ST_HOLD: begin
        if (num_okey) begin
          for (int i = 0; i < N_OPS; i++) begin
            if (k_q == KW'(i)) op_d[i] = number;
          end
        end else begin
          k_d = k_inc;
          if (k_inc == KW'(N_OPS)) begin
            state_d = ST_COMPUTE;
            a_d     = op_q[0];
            b_d     = op_q[1];
            j_d     = KW'(2);
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (num_okey) state_d = ST_HOLD;
      end
      ST_COMPUTE: begin
        if (pair_hit) begin
          if (j_q < KW'(N_OPS)) begin
            a_d = pair_val;
            b_d = op_at_j;
            j_d = j_q + KW'(1);
          end else begin
            result_d = pair_val;
            state_d  = ST_DONE;
          end
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  if (W >= 4) begin : g_nibble_wide
    assign nibble = result_q[3:0];
  end else begin : g_nibble_narrow
    assign nibble = {{(4 - W){1'b0}}, result_q};
  end

  ssd_hex u_ssd_hex (
    .hex (nibble),
    .seg (hex_seg)
  );

  always_comb begin
    result   = result_q;
    busy     = (state_q == ST_COMPUTE);
    done     = (state_q == ST_DONE);
    zero_err = done && (result_q == '0);
    case (state_q)
      ST_HOLD:    ssd = C_GLYPH_HOLD;
      ST_NEXT:    ssd = C_GLYPH_NEXT;
      ST_COMPUTE: ssd = C_GLYPH_BUSY;
      ST_DONE:    ssd = zero_err ? C_GLYPH_ERR : hex_seg;
      default:    ssd = C_GLYPH_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gcd_fold_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gcd_fold_engine : directed and random folds on W=8/N=3, W=4/N=2  |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_gcd_fold_engine;

  localparam logic [6:0] G_IDLE = 7'b1000000;
  localparam logic [6:0] G_HOLD = 7'b1011100;
  localparam logic [6:0] G_NEXT = 7'b1010100;
  localparam logic [6:0] G_ERR  = 7'b1111001;
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk = 1'b0;
  logic       rst;
  logic       okey8, okey4;
  logic [7:0] num8;
  logic [3:0] num4;
  logic [7:0] res8;
  logic [3:0] res4;
  logic       done8, busy8, zerr8, done4, busy4, zerr4;
  logic [6:0] ssd8, ssd4;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  gcd_fold_engine #(.W(8), .N_OPS(3)) dut8 (
    .clk(clk), .rst(rst), .num_okey(okey8), .number(num8), .result(res8),
    .done(done8), .busy(busy8), .zero_err(zerr8), .ssd(ssd8));

  gcd_fold_engine #(.W(4), .N_OPS(2)) dut4 (
    .clk(clk), .rst(rst), .num_okey(okey4), .number(num4), .result(res4),
    .done(done4), .busy(busy4), .zero_err(zerr4), .ssd(ssd4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] g_res(input bit sm);  return sm ? {4'b0, res4} : res8; endfunction
  function automatic logic       g_done(input bit sm); return sm ? done4 : done8; endfunction
  function automatic logic       g_busy(input bit sm); return sm ? busy4 : busy8; endfunction
  function automatic logic       g_zerr(input bit sm); return sm ? zerr4 : zerr8; endfunction
  function automatic logic [6:0] g_ssd(input bit sm);  return sm ? ssd4 : ssd8; endfunction

  task automatic drive(input bit sm, input logic ok, input logic [7:0] v);
    if (sm) begin
      okey4 = ok;
      num4  = v[3:0];
    end else begin
      okey8 = ok;
      num8  = v;
    end
  endtask

  // Reference: Euclid by remainder for the value, subtractive step rule for latency.
  function automatic int gcd2(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int steps2(input int a, input int b);
    int n = 0;
    while (!(a == b || a == 0 || b == 0)) begin
      if (a > b) a = a - b;
      else       b = b - a;
      n++;
    end
    return n + 1;
  endfunction

  task automatic model(input int n, input int vals[3], output int r, output int lat);
    r   = vals[0];
    lat = 0;
    for (int i = 1; i < n; i++) begin
      lat += steps2(r, vals[i]);
      r    = gcd2(r, vals[i]);
    end
  endtask

  task automatic enter(input bit sm, input int n, input int vals[3], input int first);
    for (int i = first; i < n; i++) begin
      @(negedge clk) drive(sm, 1'b1, 8'(vals[i]));
      @(negedge clk);
      @(negedge clk) drive(sm, 1'b0, 8'(vals[i]));
    end
  endtask

  task automatic wait_done(input string tag, input bit sm, input bit toggle, output int lat);
    bit ok  = 1'b0;
    bit gap = 1'b0;
    lat = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (g_done(sm)) begin
        ok = 1'b1;
        if (g_busy(sm)) gap = 1'b1;
        break;
      end
      if (g_busy(sm)) lat++;
      else            gap = 1'b1;
      if (toggle) drive(sm, 1'($urandom_range(0, 1)), 8'($urandom));
    end
    drive(sm, 1'b0, 8'd0);
    check({tag, "_timeout"}, 32'(ok), 32'd1);
    check({tag, "_handoff"}, 32'(gap), 32'd0);
  endtask

  task automatic finish_checks(input string tag, input bit sm, input int n, input int vals[3], input int lat);
    int er, el;
    model(n, vals, er, el);
    check({tag, "_result"}, 32'(g_res(sm)), 32'(er));
    check({tag, "_done"}, 32'(g_done(sm)), 32'd1);
    check({tag, "_zero_err"}, 32'(g_zerr(sm)), 32'(er == 0));
    check({tag, "_ssd"}, 32'(g_ssd(sm)), 32'((er == 0) ? G_ERR : HEX_GLYPH[er % 16]));
    check({tag, "_latency"}, 32'(lat), 32'(el));
  endtask

  task automatic do_fold(input string tag, input bit sm, input int n, input int vals[3], input bit toggle);
    int lat;
    enter(sm, n, vals, 0);
    wait_done(tag, sm, toggle, lat);
    finish_checks(tag, sm, n, vals, lat);
  endtask

  task automatic check_reset_outputs(input string tag, input bit sm);
    check({tag, "_result"}, 32'(g_res(sm)), 32'd0);
    check({tag, "_done"}, 32'(g_done(sm)), 32'd0);
    check({tag, "_busy"}, 32'(g_busy(sm)), 32'd0);
    check({tag, "_zero_err"}, 32'(g_zerr(sm)), 32'd0);
    check({tag, "_ssd"}, 32'(g_ssd(sm)), 32'(G_IDLE));
  endtask

  initial begin
    int v[3];
    int lat;
    int g;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset8", 1'b0);
    check_reset_outputs("reset4", 1'b1);

    v = '{12, 18, 30};
    do_fold("f12_18_30", 1'b0, 3, v, 1'b0);
    check("f12_18_30_hex6", 32'(ssd8), 32'(7'b0000010));

    v = '{0, 0, 0};
    do_fold("zeros", 1'b0, 3, v, 1'b0);
    check("zeros_err_glyph", 32'(ssd8), 32'(G_ERR));

    v = '{255, 1, 7};
    do_fold("f255_1_7", 1'b0, 3, v, 1'b0);

    // Reset while busy, then repeat the same entry.
    v = '{200, 150, 100};
    enter(1'b0, 3, v, 0);
    repeat (4) @(negedge clk);
    check("midrst_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_reset_outputs("midrst", 1'b0);
    do_fold("f200_150_100", 1'b0, 3, v, 1'b0);

    v = '{48, 180, 27};
    do_fold("toggle", 1'b0, 3, v, 1'b1);

    // Raising num_okey in DONE starts a new entry immediately.
    v = '{36, 60, 84};
    @(negedge clk) drive(1'b0, 1'b1, 8'(v[0]));
    @(negedge clk);
    check("reentry_done_clr", 32'(done8), 32'd0);
    check("reentry_zerr_clr", 32'(zerr8), 32'd0);
    check("reentry_hold_glyph", 32'(ssd8), 32'(G_HOLD));
    @(negedge clk) drive(1'b0, 1'b0, 8'(v[0]));
    @(negedge clk);
    check("reentry_next_glyph", 32'(ssd8), 32'(G_NEXT));
    enter(1'b0, 3, v, 1);
    wait_done("reentry", 1'b0, 1'b0, lat);
    finish_checks("reentry", 1'b0, 3, v, lat);

    for (int t = 0; t < 6; t++) begin
      g = int'($urandom_range(1, 20));
      for (int i = 0; i < 3; i++) v[i] = g * int'($urandom_range(0, 12));
      do_fold("rand8", 1'b0, 3, v, 1'(t % 2));
    end

    v = '{15, 10, 0};
    do_fold("w4_15_10", 1'b1, 2, v, 1'b0);
    check("w4_15_10_val", 32'(res4), 32'd5);

    for (int t = 0; t < 4; t++) begin
      v[0] = int'($urandom_range(0, 15));
      v[1] = int'($urandom_range(0, 15));
      v[2] = 0;
      do_fold("rand4", 1'b1, 2, v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
